// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
//   RV32I decode stage feeding the execute-stage register. Decodes one
//   instruction per cycle into ALU operation, operands, immediate and control
//   flags, and registers them for execute (one-cycle latency). Detects the
//   load-use hazard against the instruction currently held for execute and
//   inserts a single bubble.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   instr, instr_valid  fetched instruction and its valid qualifier
//   instr_ready         decode accepts instr this cycle (combinational)
//   pc                  address of instr
//   rs1_data, rs2_data  register-file read data for instr[19:15] / [24:20]
//   stall               execute cannot accept; hold all registered outputs
//   flush               taken branch/jump; discard decode and execute contents
//   ex_valid            registered outputs hold a live instruction
//   aluop, sign         ALU operation and signed/unsigned select
//   data1, op2          ALU operands
//   imm                 sign-extended immediate (also used by the PC adder)
//   rd                  destination register
//   regwrite, memread, memwrite, branch, jump, illegal   control flags
//   pc_out              pc of the registered instruction
// ----------------------------------------------------------------------------
module decode_stage #(
    parameter int PCW = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    instr,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [PCW-1:0] pc,
    input  logic [31:0]    rs1_data,
    input  logic [31:0]    rs2_data,
    input  logic           stall,
    input  logic           flush,
    output logic           ex_valid,
    output logic [4:0]     aluop,
    output logic           sign,
    output logic [31:0]    data1,
    output logic [31:0]    op2,
    output logic [31:0]    imm,
    output logic [4:0]     rd,
    output logic           regwrite,
    output logic           memread,
    output logic           memwrite,
    output logic           branch,
    output logic           jump,
    output logic           illegal,
    output logic [PCW-1:0] pc_out
);

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_SLL  = 5'b00010;
    localparam logic [4:0] ALU_XOR  = 5'b00011;
    localparam logic [4:0] ALU_SRL  = 5'b00100;
    localparam logic [4:0] ALU_SRA  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_PASS = 5'b01001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Immediate extraction, all sign-extended to 32 bits.
    function automatic logic signed [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic signed [31:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_u(input logic [31:0] ins);
        return {ins[31:12], 12'h000};
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    // funct3 to ALU code; sub_sel only applies to register-register ops,
    // sra_sel (funct7[5]) selects arithmetic shift for both OP and OP-IMM.
    function automatic logic [4:0] f3_aluop(input logic [2:0] f3,
                                            input logic       sub_sel,
                                            input logic       sra_sel);
        case (f3)
            3'b000:  return sub_sel ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b101:  return sra_sel ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // flags vector order: {regwrite, memread, memwrite, branch, jump, illegal}
    logic [4:0]         aluop_p0;
    logic               sign_p0;
    logic signed [31:0] op2_p0;
    logic signed [31:0] imm_p0;
    logic [5:0]         flags_p0;

    always_comb begin
        aluop_p0 = ALU_ADD;
        sign_p0  = 1'b1;
        op2_p0   = rs2_data;
        imm_p0   = imm_i(instr);
        flags_p0 = 6'b000000;
        case (opcode)
            OPC_OP: begin
                aluop_p0 = f3_aluop(funct3, instr[30], instr[30]);
                sign_p0  = (funct3 != 3'b011);
                flags_p0 = 6'b100000;
            end
            OPC_OPIMM: begin
                aluop_p0 = f3_aluop(funct3, 1'b0, instr[30]);
                sign_p0  = (funct3 != 3'b011);
                op2_p0   = imm_i(instr);
                flags_p0 = 6'b100000;
            end
            OPC_LOAD: begin
                op2_p0   = imm_i(instr);
                flags_p0 = 6'b110000;
            end
            OPC_STORE: begin
                op2_p0   = imm_s(instr);
                imm_p0   = imm_s(instr);
                flags_p0 = 6'b001000;
            end
            OPC_BRANCH: begin
                aluop_p0 = ALU_SUB;
                sign_p0  = (funct3[2:1] != 2'b11);
                imm_p0   = imm_b(instr);
                flags_p0 = 6'b000100;
            end
            OPC_LUI: begin
                aluop_p0 = ALU_PASS;
                op2_p0   = imm_u(instr);
                imm_p0   = imm_u(instr);
                flags_p0 = 6'b100000;
            end
            OPC_JAL: begin
                op2_p0   = imm_j(instr);
                imm_p0   = imm_j(instr);
                flags_p0 = 6'b100010;
            end
            OPC_JALR: begin
                op2_p0   = imm_i(instr);
                flags_p0 = 6'b100010;
            end
            default: flags_p0 = 6'b000001;
        endcase
    end

    logic               vld_p1;
    logic [4:0]         aluop_p1;
    logic               sign_p1;
    logic signed [31:0] data1_p1;
    logic signed [31:0] op2_p1;
    logic signed [31:0] imm_p1;
    logic [4:0]         rd_p1;
    logic [5:0]         flags_p1;
    logic [PCW-1:0]     pc_p1;

    // Load-use: the load in execute writes a register this instruction reads.
    // rs2 is only a real source for OP, STORE and BRANCH.
    logic uses_rs2;
    logic hazard;
    logic accept;
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign hazard   = vld_p1 && flags_p1[4] && (rd_p1 != 5'd0) &&
                      ((rd_p1 == instr[19:15]) || (uses_rs2 && (rd_p1 == instr[24:20])));
    assign accept   = instr_valid && !hazard;

    // Flush consumes the incoming instruction, so decode is ready regardless.
    assign instr_ready = flush || (!stall && !hazard);

    // ---- stage boundary: decode -> execute register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            aluop_p1 <= '0;
            sign_p1  <= 1'b0;
            data1_p1 <= '0;
            op2_p1   <= '0;
            imm_p1   <= '0;
            rd_p1    <= '0;
            flags_p1 <= '0;
            pc_p1    <= '0;
        end else if (flush) begin
            vld_p1   <= 1'b0;
            flags_p1 <= '0;
        end else if (!stall) begin
            vld_p1   <= accept;
            flags_p1 <= accept ? flags_p0 : 6'b000000;
            aluop_p1 <= aluop_p0;
            sign_p1  <= sign_p0;
            data1_p1 <= rs1_data;
            op2_p1   <= op2_p0;
            imm_p1   <= imm_p0;
            rd_p1    <= instr[11:7];
            pc_p1    <= pc;
        end
    end

    assign ex_valid = vld_p1;
    assign aluop    = aluop_p1;
    assign sign     = sign_p1;
    assign data1    = data1_p1;
    assign op2      = op2_p1;
    assign imm      = imm_p1;
    assign rd       = rd_p1;
    assign regwrite = flags_p1[5];
    assign memread  = flags_p1[4];
    assign memwrite = flags_p1[3];
    assign branch   = flags_p1[2];
    assign jump     = flags_p1[1];
    assign illegal  = flags_p1[0];
    assign pc_out   = pc_p1;

endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
//   Bench for decode_stage: directed sequences with hand-computed literal
//   expectations plus a randomized run checked every cycle against a
//   behavioural reference model of the decode/execute register.
// ----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int PCW = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    instr;
    logic           instr_valid;
    logic           instr_ready;
    logic [PCW-1:0] pc;
    logic [31:0]    rs1_data;
    logic [31:0]    rs2_data;
    logic           stall;
    logic           flush;
    logic           ex_valid;
    logic [4:0]     aluop;
    logic           sign;
    logic [31:0]    data1;
    logic [31:0]    op2;
    logic [31:0]    imm;
    logic [4:0]     rd;
    logic           regwrite, memread, memwrite, branch, jump, illegal;
    logic [PCW-1:0] pc_out;

    int checks = 0;
    int errors = 0;

    decode_stage #(.PCW(PCW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall(stall), .flush(flush), .ex_valid(ex_valid), .aluop(aluop), .sign(sign),
        .data1(data1), .op2(op2), .imm(imm), .rd(rd), .regwrite(regwrite),
        .memread(memread), .memwrite(memwrite), .branch(branch), .jump(jump),
        .illegal(illegal), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    // Expected contents of the execute register. fl = {rw, mr, mw, br, jp, il}.
    // ca/cs/co/ci mark which of aluop/sign/op2/imm the instruction defines.
    typedef struct packed {
        logic           v;
        logic [4:0]     aluop;
        logic           sign;
        logic [31:0]    d1;
        logic [31:0]    op2;
        logic [31:0]    imm;
        logic [4:0]     rd;
        logic [5:0]     fl;
        logic [PCW-1:0] pc;
        logic           ca, cs, co, ci;
    } exp_t;

    localparam logic [4:0] F3TBL [0:7] = '{5'd0, 5'd2, 5'd8, 5'd8, 5'd3, 5'd4, 5'd6, 5'd7};

    exp_t m = '0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sx(input int val, input int bits);
        if (val >= (1 << (bits - 1))) return val - (1 << bits);
        return val;
    endfunction

    function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] r1,
                                       input logic [31:0] r2, input logic [PCW-1:0] p);
        exp_t e;
        int f3, iv, sv, bv, jv;
        logic [31:0] u;
        e = '0;
        f3 = int'(ins[14:12]);
        iv = sx(int'(ins[31:20]), 12);
        sv = sx(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12);
        bv = sx(int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                + int'(ins[11:8]) * 2, 13);
        jv = sx(int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                + int'(ins[30:21]) * 2, 21);
        u  = ins & 32'hFFFF_F000;
        e.v  = 1'b1;
        e.d1 = r1;
        e.rd = ins[11:7];
        e.pc = p;
        case (ins[6:0])
            7'h33: begin
                e.aluop = F3TBL[f3];
                if (f3 == 0 && ins[30]) e.aluop = 5'd1;
                if (f3 == 5 && ins[30]) e.aluop = 5'd5;
                e.sign = (f3 != 3);
                e.op2  = r2;
                e.fl   = 6'b100000;
                e.ca = 1; e.cs = 1; e.co = 1;
            end
            7'h13: begin
                e.aluop = F3TBL[f3];
                if (f3 == 5 && ins[30]) e.aluop = 5'd5;
                e.sign = (f3 != 3);
                e.op2  = 32'(iv);
                e.imm  = 32'(iv);
                e.fl   = 6'b100000;
                e.ca = 1; e.cs = 1; e.co = 1; e.ci = 1;
            end
            7'h03: begin
                e.op2 = 32'(iv); e.imm = 32'(iv); e.fl = 6'b110000;
                e.ca = 1; e.co = 1; e.ci = 1;
            end
            7'h23: begin
                e.op2 = 32'(sv); e.imm = 32'(sv); e.fl = 6'b001000;
                e.ca = 1; e.co = 1; e.ci = 1;
            end
            7'h63: begin
                e.aluop = 5'd1;
                e.sign  = !(f3 == 6 || f3 == 7);
                e.op2   = r2;
                e.imm   = 32'(bv);
                e.fl    = 6'b000100;
                e.ca = 1; e.cs = 1; e.co = 1; e.ci = 1;
            end
            7'h37: begin
                e.aluop = 5'd9; e.op2 = u; e.imm = u; e.fl = 6'b100000;
                e.ca = 1; e.co = 1; e.ci = 1;
            end
            7'h6F: begin
                e.imm = 32'(jv); e.fl = 6'b100010; e.ci = 1;
            end
            7'h67: begin
                e.op2 = 32'(iv); e.imm = 32'(iv); e.fl = 6'b100010;
                e.ca = 1; e.co = 1; e.ci = 1;
            end
            default: e.fl = 6'b000001;
        endcase
        return e;
    endfunction

    function automatic logic haz(input exp_t s, input logic [31:0] ins);
        logic use2;
        use2 = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
        return s.v && s.fl[4] && (s.rd != 0) &&
               ((s.rd == ins[19:15]) || (use2 && s.rd == ins[24:20]));
    endfunction

    // Reference model of the execute register.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '0;
        end else if (flush) begin
            m.v  <= 1'b0;
            m.fl <= '0;
        end else if (!stall) begin
            if (instr_valid && !haz(m, instr)) begin
                m <= model_dec(instr, rs1_data, rs2_data, pc);
            end else begin
                m.v  <= 1'b0;
                m.fl <= '0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            cmp("rst_ex_valid", 32'(ex_valid), 32'd0);
            cmp("rst_flags", 32'({regwrite, memread, memwrite, branch, jump, illegal}), 32'd0);
            cmp("rst_data", data1 | op2 | imm | 32'(aluop) | 32'(rd) | 32'(pc_out) | 32'(sign), 32'd0);
        end else if (rst === 1'b0) begin
            cmp("ex_valid", 32'(ex_valid), 32'(m.v));
            cmp("flags", 32'({regwrite, memread, memwrite, branch, jump, illegal}), 32'(m.fl));
            cmp("instr_ready", 32'(instr_ready), 32'(flush || (!stall && !haz(m, instr))));
            if (m.v) begin
                cmp("data1", data1, m.d1);
                cmp("rd", 32'(rd), 32'(m.rd));
                cmp("pc_out", 32'(pc_out), 32'(m.pc));
                if (m.ca) cmp("aluop", 32'(aluop), 32'(m.aluop));
                if (m.cs) cmp("sign", 32'(sign), 32'(m.sign));
                if (m.co) cmp("op2", op2, m.op2);
                if (m.ci) cmp("imm", imm, m.imm);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] i, input logic v, input logic [31:0] a,
                       input logic [31:0] b);
        instr       = i;
        instr_valid = v;
        rs1_data    = a;
        rs2_data    = b;
        pc          = pc + 12'd4;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [0:12];
        logic [31:0] ins;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h67,
                 7'h03, 7'h33, 7'h7F, 7'h17, 7'h73};
        ins         = $urandom;
        ins[6:0]    = opcs[$urandom_range(0, 12)];
        ins[11:7]   = 5'($urandom_range(0, 3));
        ins[19:15]  = 5'($urandom_range(0, 3));
        ins[24:20]  = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    initial begin
        rst = 1'b1;
        instr = '0; instr_valid = 1'b0; pc = 12'h0FC;
        rs1_data = '0; rs2_data = '0; stall = 1'b0; flush = 1'b0;
        tick();
        tick();
        cmp("reset_ex_valid_lit", 32'(ex_valid), 32'd0);
        cmp("reset_pc_out_lit", 32'(pc_out), 32'd0);
        rst = 1'b0;

        // ADDI x5,x1,-3 accepted on the first edge after reset
        put(32'hFFD08293, 1'b1, 32'd7, 32'h1234);
        tick();
        cmp("addi_ex_valid", 32'(ex_valid), 32'd1);
        cmp("addi_aluop", 32'(aluop), 32'd0);
        cmp("addi_data1", data1, 32'd7);
        cmp("addi_op2", op2, 32'hFFFF_FFFD);
        cmp("addi_rd", 32'(rd), 32'd5);
        cmp("addi_regwrite", 32'(regwrite), 32'd1);

        // SUB x3,x1,x2 then SLTU x3,x1,x2
        put(32'h402081B3, 1'b1, 32'd10, 32'd3);
        tick();
        cmp("sub_aluop", 32'(aluop), 32'd1);
        cmp("sub_sign", 32'(sign), 32'd1);
        cmp("sub_op2", op2, 32'd3);
        cmp("sub_rd", 32'(rd), 32'd3);
        put(32'h0020B1B3, 1'b1, 32'd10, 32'd3);
        tick();
        cmp("sltu_aluop", 32'(aluop), 32'd8);
        cmp("sltu_sign", 32'(sign), 32'd0);

        // LW x6,0(x2) followed by dependent ADD x7,x6,x1
        put(32'h00012303, 1'b1, 32'h100, 32'd0);
        tick();
        cmp("lw_memread", 32'(memread), 32'd1);
        put(32'h001303B3, 1'b1, 32'd55, 32'd66);
        #1;
        cmp("luse_ready_low", 32'(instr_ready), 32'd0);
        tick();
        cmp("luse_bubble", 32'(ex_valid), 32'd0);
        cmp("luse_bubble_rw", 32'(regwrite), 32'd0);
        cmp("luse_ready_back", 32'(instr_ready), 32'd1);
        tick();
        cmp("luse_add_valid", 32'(ex_valid), 32'd1);
        cmp("luse_add_rd", 32'(rd), 32'd7);

        // BEQ x1,x2,+8 held by three stall cycles, then flushed under stall
        put(32'h00208463, 1'b1, 32'd1, 32'd2);
        tick();
        cmp("beq_branch", 32'(branch), 32'd1);
        cmp("beq_imm", imm, 32'd8);
        stall = 1'b1;
        put(32'hFFD08293, 1'b1, 32'd9, 32'd9);
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp("stall_branch", 32'(branch), 32'd1);
            cmp("stall_imm", imm, 32'd8);
            cmp("stall_aluop", 32'(aluop), 32'd1);
            cmp("stall_ready", 32'(instr_ready), 32'd0);
        end
        flush = 1'b1;
        #1;
        cmp("flush_ready", 32'(instr_ready), 32'd1);
        tick();
        cmp("flush_ex_valid", 32'(ex_valid), 32'd0);
        cmp("flush_branch", 32'(branch), 32'd0);
        flush = 1'b0;
        stall = 1'b0;

        // Undefined opcode, then asynchronous reset between edges
        put(32'h0000007F, 1'b1, 32'd3, 32'd4);
        tick();
        cmp("illegal_flag", 32'(illegal), 32'd1);
        cmp("illegal_rw", 32'(regwrite), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        cmp("async_rst_valid", 32'(ex_valid), 32'd0);
        cmp("async_rst_illegal", 32'(illegal), 32'd0);
        cmp("async_rst_data1", data1, 32'd0);
        tick();
        rst = 1'b0;
        put(32'hFFD08293, 1'b1, 32'd7, 32'd0);
        tick();
        cmp("post_rst_valid", 32'(ex_valid), 32'd1);
        cmp("post_rst_rd", 32'(rd), 32'd5);

        // Randomized traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                stall = ($urandom_range(0, 99) < 15);
                flush = ($urandom_range(0, 99) < 7);
                put(rand_instr(), ($urandom_range(0, 99) < 85), $urandom, $urandom);
                tick();
            end
        end
        stall = 1'b0;
        flush = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
